square_period_meter: RTL and testbench

- Parametrised successor to the single-channel square-wave frequency detector.
- Measures period and high time of a 1-bit square wave in `clk` cycles and averages over 2^AVG_LOG2 periods.
- Flags stability against a tolerance window and flags loss of signal on timeout.
- Sits between a comparator/GPIO input and the display/control logic that consumes `period`, `high_time` and `stable`.

---
 rtl/square_period_meter.sv | 158 +++++++++++++++
 tb/tb_square_period_meter.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/square_period_meter.sv
// Square-wave period / high-time meter: averages 2^AVG_LOG2 periods, flags
// stability within TOL cycles and loss of signal after TIMEOUT idle cycles.
module square_period_meter #(
    parameter int CNT_W    = 18,
    parameter int AVG_LOG2 = 2,
    parameter int STABLE_N = 4,
    parameter int TOL      = 2,
    parameter int TIMEOUT  = 2**18-1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             signal_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             valid,
    output logic             stable,
    output logic             lost
);
    localparam int ACC_W = CNT_W + AVG_LOG2;
    localparam int SMP_W = AVG_LOG2 + 1;
    localparam int DIF_W = CNT_W + 1;
    localparam int SC_W  = (STABLE_N < 1) ? 1 : $clog2(STABLE_N + 1);
    localparam logic [CNT_W-1:0] TIMEOUT_V = CNT_W'(TIMEOUT);
    localparam logic [SMP_W-1:0] LAST_SMP  = SMP_W'((1 << AVG_LOG2) - 1);
    localparam logic [SC_W-1:0]  STABLE_V  = SC_W'(STABLE_N);
    localparam logic [DIF_W-1:0] TOL_V     = DIF_W'(TOL);

    typedef enum logic {IDLE, MEASURE} state_t;
    state_t state, state_nxt;

    logic             s1, s2, s3;
    logic             rise, fall;
    logic             arm, timeout, sample;
    logic [CNT_W-1:0] cnt, hi_raw, prev_p, avg_p, avg_h;
    logic [ACC_W-1:0] acc_p, acc_h;
    logic [SMP_W-1:0] smp_cnt;
    logic [SC_W-1:0]  stable_cnt, stable_cnt_nxt;
    logic             have_prev, vld_p0, in_tol;

    function automatic logic [DIF_W-1:0] abs_diff(input logic [CNT_W-1:0] a,
                                                  input logic [CNT_W-1:0] b);
        return (a >= b) ? ({1'b0, a} - {1'b0, b}) : ({1'b0, b} - {1'b0, a});
    endfunction

    function automatic logic [SC_W-1:0] sat_inc(input logic [SC_W-1:0] v);
        return (v >= STABLE_V) ? STABLE_V : v + 1'b1;
    endfunction

    // Stage 0: synchroniser and edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= signal_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise = s2 & ~s3;
    assign fall = ~s2 & s3;

    // Stage 1: cycle counter (saturating, so a dead input never wraps) and high-time capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            hi_raw <= '0;
        end else begin
            if (rise)
                cnt <= CNT_W'(1);
            else if (cnt != TIMEOUT_V)
                cnt <= cnt + 1'b1;
            if (fall)
                hi_raw <= cnt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        arm       = 1'b0;
        timeout   = 1'b0;
        sample    = 1'b0;
        if (clr) begin
            state_nxt = IDLE;
        end else if (state == IDLE) begin
            if (rise) begin
                arm       = 1'b1;
                state_nxt = MEASURE;
            end
        end else if (cnt == TIMEOUT_V && !rise) begin
            timeout   = 1'b1;
            state_nxt = IDLE;
        end else if (rise) begin
            sample = 1'b1;
        end
    end

    assign avg_p          = acc_p[ACC_W-1 -: CNT_W];
    assign avg_h          = acc_h[ACC_W-1 -: CNT_W];
    assign in_tol         = abs_diff(avg_p, prev_p) <= TOL_V;
    assign stable_cnt_nxt = (have_prev && in_tol) ? sat_inc(stable_cnt) : '0;

    // Stage 2: window accumulation; vld_p0 marks a completed window, published next cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_p      <= '0;
            acc_h      <= '0;
            smp_cnt    <= '0;
            vld_p0     <= 1'b0;
            period     <= '0;
            high_time  <= '0;
            valid      <= 1'b0;
            prev_p     <= '0;
            have_prev  <= 1'b0;
            stable_cnt <= '0;
            stable     <= 1'b0;
            lost       <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (clr || timeout) begin
                acc_p      <= '0;
                acc_h      <= '0;
                smp_cnt    <= '0;
                vld_p0     <= 1'b0;
                have_prev  <= 1'b0;
                stable_cnt <= '0;
                stable     <= 1'b0;
                lost       <= timeout;
            end else begin
                acc_p  <= (vld_p0 ? '0 : acc_p) + (sample ? ACC_W'(cnt) : '0);
                acc_h  <= (vld_p0 ? '0 : acc_h) + (sample ? ACC_W'(hi_raw) : '0);
                vld_p0 <= sample && (smp_cnt == LAST_SMP);
                if (sample)
                    smp_cnt <= (smp_cnt == LAST_SMP) ? '0 : smp_cnt + 1'b1;
                if (arm)
                    lost <= 1'b0;
                // Stage 3: publish averages and update stability
                if (vld_p0) begin
                    period     <= avg_p;
                    high_time  <= avg_h;
                    valid      <= 1'b1;
                    prev_p     <= avg_p;
                    have_prev  <= 1'b1;
                    stable_cnt <= stable_cnt_nxt;
                    stable     <= (stable_cnt_nxt == STABLE_V);
                end
            end
        end
    end
endmodule

// File: tb/tb_square_period_meter.sv
// Randomised self-checking bench for square_period_meter against an
// event-level reference model (edge times, sample queues, window averages).
module tb_square_period_meter;
    localparam int TO   = 1000;
    localparam int NAVG = 4;
    localparam int STN  = 4;
    localparam int TOLC = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clr = 1'b0;
    logic        signal_in = 1'b0;
    logic [17:0] period, high_time;
    logic        valid, stable, lost;

    square_period_meter #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .signal_in(signal_in),
        .period(period), .high_time(high_time), .valid(valid),
        .stable(stable), .lost(lost)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // reference model state
    int   k = 0;
    logic [2:0] xh = '0;
    int   load = 1;
    int   hi_raw = 0;
    bit   measuring = 0;
    int   win_p[$];
    int   win_h[$];
    bit   pend = 0;
    int   pend_p = 0, pend_h = 0;
    bit   have_prev = 0;
    int   prev_avg = 0;
    int   scnt = 0;
    int   e_period = 0, e_high = 0;
    bit   e_valid = 0, e_stable = 0, e_lost = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp, k);
        end
    endtask

    task automatic drop_measurement();
        measuring = 0;
        win_p.delete();
        win_h.delete();
        pend = 0;
        have_prev = 0;
        scnt = 0;
        e_stable = 0;
    endtask

    // Predicts DUT outputs after the upcoming clock edge.
    task automatic model_edge(input logic v, input logic c);
        logic r, f;
        int   cntv, sp, sh, d;
        k++;
        if (!rst_n) begin
            xh = '0; load = k + 1; hi_raw = 0;
            drop_measurement();
            e_lost = 0; e_valid = 0; e_period = 0; e_high = 0;
            return;
        end
        r = xh[1] & ~xh[2];
        f = ~xh[1] & xh[2];
        xh = {xh[1:0], v};
        cntv = (k - load > TO) ? TO : k - load;
        e_valid = 0;
        if (c) begin
            drop_measurement();
            e_lost = 0;
        end else begin
            if (pend) begin
                pend = 0;
                e_valid = 1;
                e_period = pend_p;
                e_high = pend_h;
                if (have_prev) begin
                    d = pend_p - prev_avg;
                    if (d < 0) d = -d;
                    scnt = (d <= TOLC) ? ((scnt + 1 > STN) ? STN : scnt + 1) : 0;
                end else begin
                    scnt = 0;
                end
                have_prev = 1;
                prev_avg = pend_p;
                e_stable = (scnt == STN);
            end
            if (!measuring) begin
                if (r) begin
                    measuring = 1;
                    e_lost = 0;
                end
            end else if (cntv == TO && !r) begin
                drop_measurement();
                e_lost = 1;
            end else if (r) begin
                win_p.push_back(cntv);
                win_h.push_back(hi_raw);
                if (win_p.size() == NAVG) begin
                    sp = 0; sh = 0;
                    foreach (win_p[i]) sp += win_p[i];
                    foreach (win_h[i]) sh += win_h[i];
                    pend_p = sp / NAVG;
                    pend_h = sh / NAVG;
                    pend = 1;
                    win_p.delete();
                    win_h.delete();
                end
            end
        end
        if (r) load = k;
        if (f) hi_raw = cntv;
    endtask

    task automatic tick(input logic v, input logic c);
        @(negedge clk);
        signal_in = v;
        clr = c;
        model_edge(v, c);
        @(posedge clk);
        #1;
        check("valid", valid, e_valid);
        check("lost", lost, e_lost);
        check("stable", stable, e_stable);
        check("period", period, e_period);
        check("high_time", high_time, e_high);
    endtask

    task automatic wave(input int hi, input int lo, input int n);
        for (int p = 0; p < n; p++) begin
            for (int i = 0; i < hi; i++) tick(1'b1, 1'b0);
            for (int i = 0; i < lo; i++) tick(1'b0, 1'b0);
        end
    endtask

    task automatic check_outs(input string tag, input int p, input int h,
                              input logic s, input logic l);
        check({tag, "_period"}, period, p);
        check({tag, "_high"}, high_time, h);
        check({tag, "_stable"}, stable, s);
        check({tag, "_lost"}, lost, l);
    endtask

    initial begin
        // reset held while the input toggles
        for (int i = 0; i < 12; i++) tick(i[1], 1'b0);
        check_outs("rst", 0, 0, 1'b0, 1'b0);
        check("rst_valid", valid, 0);
        rst_n = 1'b1;

        wave(20, 20, 100);
        check_outs("p40", 40, 20, 1'b1, 1'b0);

        wave(30, 30, 40);
        check_outs("p60", 60, 30, 1'b1, 1'b0);

        wave(10, 30, 40);
        check_outs("duty", 40, 10, 1'b1, 1'b0);
        for (int p = 0; p < 40; p++) begin
            int hi;
            hi = 10;
            if (p % 2 == 1) hi = ($urandom_range(0, 1) == 1) ? 11 : 9;
            wave(hi, 30, 1);
        end
        check("jitter_stable", stable, 1);
        wave(10, 30, 12);

        for (int i = 0; i < 1200; i++) tick(1'b0, 1'b0);
        check_outs("timeout", 40, 10, 1'b0, 1'b1);

        wave(20, 20, 10);
        check_outs("resume", 40, 20, 1'b0, 1'b0);

        // clr mid-window
        wave(20, 20, 2);
        for (int i = 0; i < 25; i++) tick(1'b1, 1'b0);
        tick(1'b1, 1'b1);
        check("clr_stable", stable, 0);
        check("clr_lost", lost, 0);
        wave(20, 20, 10);

        // reset mid-window
        wave(20, 20, 2);
        for (int i = 0; i < 10; i++) tick(1'b1, 1'b0);
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b0);
        check_outs("rst_mid", 0, 0, 1'b0, 1'b0);
        rst_n = 1'b1;
        wave(20, 20, 10);
        check_outs("after_rst", 40, 20, 1'b0, 1'b0);

        // randomised segments: varied duty, occasional clr and dropouts
        for (int s = 0; s < 40; s++) begin
            int hi, lo, n;
            hi = $urandom_range(3, 60);
            lo = $urandom_range(3, 60);
            n  = $urandom_range(2, 9);
            wave(hi, lo, n);
            if ($urandom_range(0, 5) == 0) tick(signal_in, 1'b1);
            if ($urandom_range(0, 7) == 0) begin
                n = $urandom_range(900, 1100);
                for (int i = 0; i < n; i++) tick(1'b0, 1'b0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
